// File: rtl/mic_array_controller_if.sv
// Sample stream from the microphone array controller into the audio DSP chain.
// The controller drives the master side and the consumer drives out_ready.
interface mic_array_controller_if #(
   parameter int NUM_LINES    = 2,
   parameter int SAMPLE_WIDTH = 24
);
   localparam int CH_W = $clog2(2 * NUM_LINES);

   logic [SAMPLE_WIDTH-1:0] out_data;
   logic [CH_W-1:0]         out_channel;
   logic                    out_last;
   logic                    out_valid;
   logic                    out_ready;

   modport master (output out_data, out_channel, out_last, out_valid, input out_ready);
   modport slave  (input out_data, out_channel, out_last, out_valid, output out_ready);
endinterface

// File: rtl/mic_array_controller.sv
// I2S master for the MEMS microphone array: generates SCK/WS, captures NUM_LINES data lines
// and drains each completed slot onto one valid/ready sample stream.
//
// state    | meaning
// ST_IDLE  | holding buffer empty, out_valid low
// ST_DRAIN | presenting buffered entries line 0..NUM_LINES-1
module mic_array_controller #(
   parameter int NUM_LINES    = 2,
   parameter int SCK_DIV      = 16,
   parameter int SAMPLE_WIDTH = 24
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 enable_in,
   input  logic [NUM_LINES-1:0] mic_data_in,
   output logic                 mic_sck_out,
   output logic                 mic_ws_out,
   output logic                 overrun_out,
   input  logic                 clear_overrun_in,
   mic_array_controller_if.master out_if
);
   localparam int CH_W  = $clog2(2 * NUM_LINES);
   localparam int DIV_W = $clog2(SCK_DIV);
   localparam int IDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
   localparam logic [DIV_W-1:0] DIV_TC    = DIV_W'(SCK_DIV - 1);
   localparam logic [4:0]       K_LAST    = 5'(SAMPLE_WIDTH);
   localparam logic [IDX_W-1:0] IDX_FIRST = '0;
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_LINES - 1);

   typedef enum logic {ST_IDLE, ST_DRAIN} state_t;

   logic [NUM_LINES-1:0]    sync1_q, sync2_q;
   logic [DIV_W-1:0]        div_q;
   logic                    sck_q;
   logic [5:0]              bit_q;
   logic [SAMPLE_WIDTH-1:0] shift_q [NUM_LINES];
   logic                    load_q, load_ws_q;
   logic [SAMPLE_WIDTH-1:0] buf_q [NUM_LINES];
   logic                    buf_ws_q;
   state_t                  state_q;
   logic [IDX_W-1:0]        idx_q;
   logic                    valid_q, last_q, ovr_q;
   logic [SAMPLE_WIDTH-1:0] data_q;
   logic [CH_W-1:0]         chan_q;

   logic             tick, sample_en, in_window, hs;
   logic [IDX_W-1:0] idx_nxt;

   function automatic logic [CH_W-1:0] chan_of(input logic [IDX_W-1:0] line, input logic ws);
      return CH_W'({line, ws});
   endfunction

   function automatic logic is_last(input logic [IDX_W-1:0] line, input logic ws);
      return (line == IDX_LAST) && ws;
   endfunction

   assign tick      = (div_q == DIV_TC);
   // Last clk of the SCK high phase: data has been stable for the whole bit.
   assign sample_en = enable_in && tick && sck_q;
   assign in_window = (bit_q[4:0] != 5'd0) && (bit_q[4:0] <= K_LAST);
   assign hs        = valid_q && out_if.out_ready;
   assign idx_nxt   = idx_q + IDX_W'(1);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         div_q <= '0;
         sck_q <= 1'b0;
         bit_q <= '0;
      end else if (!enable_in) begin
         div_q <= '0;
         sck_q <= 1'b0;
         bit_q <= '0;
      end else begin
         div_q <= tick ? '0 : div_q + DIV_W'(1);
         if (tick) begin
            sck_q <= ~sck_q;
            if (sck_q) bit_q <= bit_q + 6'd1;
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         shift_q   <= '{default: '0};
         load_q    <= 1'b0;
         load_ws_q <= 1'b0;
      end else begin
         sync1_q <= mic_data_in;
         sync2_q <= sync1_q;
         load_q  <= sample_en && (bit_q[4:0] == K_LAST);
         if (sample_en) load_ws_q <= bit_q[5];
         if (sample_en && in_window) begin
            for (int l = 0; l < NUM_LINES; l++) begin
               shift_q[l] <= {shift_q[l][SAMPLE_WIDTH-2:0], sync2_q[l]};
            end
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         buf_q    <= '{default: '0};
         buf_ws_q <= 1'b0;
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         valid_q  <= 1'b0;
         data_q   <= '0;
         chan_q   <= '0;
         last_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         if (load_q) begin
            buf_q    <= shift_q;
            buf_ws_q <= load_ws_q;
            state_q  <= ST_DRAIN;
            idx_q    <= IDX_FIRST;
            valid_q  <= 1'b1;
            data_q   <= shift_q[0];
            chan_q   <= chan_of(IDX_FIRST, load_ws_q);
            last_q   <= is_last(IDX_FIRST, load_ws_q);
         end else if (state_q == ST_DRAIN && hs) begin
            if (idx_q == IDX_LAST) begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
            end else begin
               idx_q  <= idx_nxt;
               data_q <= buf_q[idx_nxt];
               chan_q <= chan_of(idx_nxt, buf_ws_q);
               last_q <= is_last(idx_nxt, buf_ws_q);
            end
         end
         // A final-entry handshake coinciding with the reload leaves nothing unread.
         if (load_q && state_q == ST_DRAIN && !(hs && idx_q == IDX_LAST)) ovr_q <= 1'b1;
         else if (clear_overrun_in) ovr_q <= 1'b0;
      end
   end

   assign mic_sck_out        = sck_q;
   assign mic_ws_out         = bit_q[5];
   assign overrun_out        = ovr_q;
   assign out_if.out_valid   = valid_q;
   assign out_if.out_data    = data_q;
   assign out_if.out_channel = chan_q;
   assign out_if.out_last    = last_q;
endmodule

// File: tb/tb_mic_array_controller.sv
// Bench for mic_array_controller: I2S mic model plus a per-slot expectation queue;
// directed steps in one initial block, sample stream checked on every handshake.
module tb_mic_array_controller;
   localparam int NL = 2;
   localparam int SW = 24;

   typedef struct {
      logic [SW-1:0] data;
      logic [1:0]    ch;
      logic          last;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst, enable, clr;
   logic [NL-1:0] mic_data;
   logic          sck, ws, ovr;
   bit            en_q = 1'b0;

   int checks = 0;
   int failures = 0;
   int pops = 0;

   exp_t          exp_q[$];
   exp_t          held;
   logic [SW-1:0] words [NL][2];
   logic [5:0]    kb = '0;
   logic          sck_prev = 1'b0;
   bit            rand_mode = 1'b0;
   bit            exp_ovr = 1'b0;
   bit            stall_prev = 1'b0, bubble_prev = 1'b0, pushed_prev = 1'b0;

   mic_array_controller_if #(.NUM_LINES(NL), .SAMPLE_WIDTH(SW)) bus ();

   mic_array_controller #(.NUM_LINES(NL), .SCK_DIV(4), .SAMPLE_WIDTH(SW)) dut (
      .clk_in          (clk),
      .rst_in          (rst),
      .enable_in       (enable),
      .mic_data_in     (mic_data),
      .mic_sck_out     (sck),
      .mic_ws_out      (ws),
      .overrun_out     (ovr),
      .clear_overrun_in(clr),
      .out_if          (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) en_q <= enable;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Consumer monitor first, then the mic model, so a final handshake in the load cycle
   // empties the expectation queue before the next slot is pushed.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         exp_q.delete();
         stall_prev  = 1'b0;
         bubble_prev = 1'b0;
         pushed_prev = 1'b0;
         kb          = '0;
         sck_prev    = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("stall_valid", bus.out_valid, 1);
            if (!pushed_prev) begin
               chk("stall_data", bus.out_data, held.data);
               chk("stall_chan", bus.out_channel, held.ch);
               chk("stall_last", bus.out_last, held.last);
            end
         end
         if (bubble_prev) chk("no_bubble", bus.out_valid, 1);
         bubble_prev = 1'b0;
         if (bus.out_valid && exp_q.size() == 0) begin
            chk("unexpected_valid", bus.out_valid, 0);
         end else if (bus.out_valid && bus.out_ready) begin
            e = exp_q.pop_front();
            chk("out_data", bus.out_data, e.data);
            chk("out_chan", bus.out_channel, e.ch);
            chk("out_last", bus.out_last, e.last);
            pops++;
            bubble_prev = (e.ch >> 1) != NL - 1;
         end
         stall_prev  = bus.out_valid && !bus.out_ready;
         held.data   = bus.out_data;
         held.ch     = bus.out_channel;
         held.last   = bus.out_last;
         pushed_prev = 1'b0;

         if (!en_q) begin
            kb       = '0;
            sck_prev = 1'b0;
            chk("idle_sck_ws", {sck, ws}, 0);
         end else begin
            if (sck_prev && !sck) begin
               kb = kb + 6'd1;
               if (rand_mode && kb[4:0] == 5'd0)
                  for (int l = 0; l < NL; l++) words[l][kb[5]] = 24'($urandom);
               if (int'(kb[4:0]) == SW + 1) begin
                  if (exp_q.size() != 0) begin
                     exp_ovr = 1'b1;
                     exp_q.delete();
                  end
                  for (int l = 0; l < NL; l++) begin
                     e.data = words[l][kb[5]];
                     e.ch   = 2'(2 * l + int'(kb[5]));
                     e.last = (l == NL - 1) && kb[5];
                     exp_q.push_back(e);
                  end
                  pushed_prev = 1'b1;
               end
            end
            sck_prev = sck;
            chk("ws_vs_bitcount", ws, kb[5]);
         end
      end
      for (int l = 0; l < NL; l++) begin
         int k;
         k = int'(kb[4:0]);
         if (k >= 1 && k <= SW) mic_data[l] = words[l][kb[5]][SW-k];
         else mic_data[l] = 1'($urandom);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string tag, input int max, output int n);
      n = 0;
      while (!bus.out_valid && n < max) begin step(); n++; end
      chk(tag, bus.out_valid, 1);
   endtask

   task automatic wait_kb(input string tag, input logic [4:0] k, input int max);
      int n = 0;
      while (kb[4:0] != k && n < max) begin step(); n++; end
      chk(tag, kb[4:0], k);
   endtask

   task automatic wait_drained(input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || bus.out_valid) && n < 600) begin step(); n++; end
      chk(tag, exp_q.size(), 0);
   endtask

   initial begin
      int n, m;
      rst = 1'b1; enable = 1'b0; clr = 1'b0; mic_data = '0;
      bus.out_ready = 1'b0;
      words[0][0] = 24'hABCDEF; words[1][0] = 24'h123456;
      words[0][1] = 24'h800001; words[1][1] = 24'h7FFFFF;
      repeat (3) step();
      chk("reset_outputs", {sck, ws, bus.out_valid, bus.out_last, ovr, bus.out_channel, bus.out_data}, 0);
      rst = 1'b0;
      repeat (3) step();

      // SCK/WS timing and the fixed-word frame
      bus.out_ready = 1'b1;
      enable = 1'b1;
      n = 0;
      while (!sck && n < 20) begin step(); n++; end
      chk("first_sck_rise", n, 4);
      n = 0;
      while (sck && n < 20) begin step(); n++; end
      m = 0;
      while (!sck && m < 20) begin step(); m++; end
      chk("sck_high_len", n, 4);
      chk("sck_period", n + m, 8);
      n = 0;
      while (!ws && n < 600) begin step(); n++; end
      chk("ws_rise_seen", ws, 1);
      chk("ws_rise_with_sck_low", sck, 0);
      n = 0;
      while (ws && n < 600) begin step(); n++; end
      chk("ws_fall_with_sck_low", sck, 0);
      m = 0;
      while (!ws && m < 600) begin step(); m++; end
      chk("ws_high_len", n, 256);
      chk("ws_period", n + m, 512);
      chk("fixed_frame_pops", pops >= 4, 1);

      // random words, random back-pressure
      rand_mode = 1'b1;
      repeat (1600) begin
         bus.out_ready = ($urandom % 4) != 0;
         step();
      end
      bus.out_ready = 1'b1;
      wait_drained("random_drained");
      chk("random_no_overrun", ovr, exp_ovr);

      // short stall inside a drain
      wait_valid("stall_wait_valid", 600, n);
      bus.out_ready = 1'b0;
      repeat (20) step();
      chk("stall_valid_held", bus.out_valid, 1);
      bus.out_ready = 1'b1;
      wait_drained("stall_drained");
      chk("stall_no_overrun", ovr, 0);

      // stall longer than a slot
      wait_kb("ovr_wait_k24", 5'd24, 600);
      bus.out_ready = 1'b0;
      repeat (300) step();
      chk("overrun_set", ovr, 1);
      chk("overrun_model", ovr, exp_ovr);
      bus.out_ready = 1'b1;
      wait_drained("overrun_drained");
      clr = 1'b1;
      step();
      clr = 1'b0;
      exp_ovr = 1'b0;
      chk("overrun_cleared", ovr, 0);

      // enable dropped mid-slot
      wait_kb("en_wait_k10", 5'd10, 600);
      enable = 1'b0;
      step();
      chk("disable_sck_ws", {sck, ws}, 0);
      repeat (100) step();
      chk("disable_no_valid", bus.out_valid, 0);
      enable = 1'b1;
      chk("reenable_ws_left", ws, 0);
      wait_valid("reenable_valid", 700, n);
      chk("reenable_latency", n, 201);
      chk("reenable_left_slot", bus.out_channel[0], 0);
      wait_drained("reenable_drained");

      // reset while a sample is being presented
      wait_valid("rst_wait_valid", 600, n);
      rst = 1'b1;
      #1;
      chk("midrst_outputs", {sck, ws, bus.out_valid, bus.out_last, ovr, bus.out_channel, bus.out_data}, 0);
      exp_ovr = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      wait_valid("postrst_valid", 700, n);
      chk("postrst_latency", n, 201);
      wait_drained("final_drained");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
